// File: rtl/vpu_reg_port_pkg.sv
// Shared types and sizes for the VPU register-file port.
// Default TIMEOUT_CYCLES applies only when VPU_REG_PORT_TIMEOUT_EN is defined.
package vpu_reg_port_pkg;

  localparam int unsigned NUM_VREG               = 8;
  localparam int unsigned RES_WORDS              = 9;
  localparam int unsigned DATA_W                 = 16;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 256;

  localparam int unsigned IDX_W  = $clog2(NUM_VREG);
  localparam int unsigned RIDX_W = $clog2(RES_WORDS);

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StRecv,
    StWrite
  } state_e;

  // Receive index 8 is the return object, the final word of a result.
  function automatic logic is_last_res(input logic [RIDX_W-1:0] ridx);
    return ridx == RIDX_W'(RES_WORDS - 1);
  endfunction

endpackage

// File: rtl/vreg_serializer.sv
// Snapshot of the eight vertex registers plus the valid/ready word serializer
// that streams them to the VPU core while the port is in SEND.
module vreg_serializer
  import vpu_reg_port_pkg::*;
(
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_capture,
  input  logic [NUM_VREG-1:0][DATA_W-1:0]  i_read_data,
  input  logic                             i_active,
  input  logic                             i_out_ready,
  output logic [DATA_W-1:0]                o_out_data,
  output logic [IDX_W-1:0]                 o_out_idx,
  output logic                             o_out_valid,
  output logic                             o_last
);

  logic [NUM_VREG-1:0][DATA_W-1:0] r_snap;
  logic [IDX_W-1:0]                r_idx;
  logic                            w_accept;
  logic                            w_at_last;

  assign w_accept  = i_active && i_out_ready;
  assign w_at_last = (r_idx == IDX_W'(NUM_VREG - 1));

  // The index saturates at the last word; only a new capture rewinds it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_snap <= '0;
      r_idx  <= '0;
    end else if (i_capture) begin
      r_snap <= i_read_data;
      r_idx  <= '0;
    end else if (w_accept && !w_at_last) begin
      r_idx <= r_idx + 1'b1;
    end
  end

  assign o_out_valid = i_active;
  assign o_out_data  = i_active ? r_snap[r_idx] : '0;
  assign o_out_idx   = i_active ? r_idx : '0;
  assign o_last      = w_accept && w_at_last;

endmodule

// File: rtl/vpu_reg_port.sv
// Register-file port of the VPU: snapshot/send the vertex registers, collect nine
// result words, write them back in one cycle. Optional RECV timeout: VPU_REG_PORT_TIMEOUT_EN.
module vpu_reg_port
  import vpu_reg_port_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_read_v0,
  input  logic [DATA_W-1:0] i_read_v1,
  input  logic [DATA_W-1:0] i_read_v2,
  input  logic [DATA_W-1:0] i_read_v3,
  input  logic [DATA_W-1:0] i_read_v4,
  input  logic [DATA_W-1:0] i_read_v5,
  input  logic [DATA_W-1:0] i_read_v6,
  input  logic [DATA_W-1:0] i_read_v7,
  output logic [DATA_W-1:0] o_out_data,
  output logic [IDX_W-1:0]  o_out_idx,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  input  logic [DATA_W-1:0] i_res_data,
  input  logic              i_res_valid,
  output logic              o_res_ready,
  output logic [DATA_W-1:0] o_wrt_v0,
  output logic [DATA_W-1:0] o_wrt_v1,
  output logic [DATA_W-1:0] o_wrt_v2,
  output logic [DATA_W-1:0] o_wrt_v3,
  output logic [DATA_W-1:0] o_wrt_v4,
  output logic [DATA_W-1:0] o_wrt_v5,
  output logic [DATA_W-1:0] o_wrt_v6,
  output logic [DATA_W-1:0] o_wrt_v7,
  output logic [DATA_W-1:0] o_return_obj,
  output logic              o_we_vpu,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e                           r_state;
  state_e                           w_state_next;
  logic [RES_WORDS-1:0][DATA_W-1:0] r_res;
  logic [RIDX_W-1:0]                r_ridx;
  logic [NUM_VREG-1:0][DATA_W-1:0]  w_read_data;
  logic                             w_capture;
  logic                             w_send_active;
  logic                             w_send_last;
  logic                             w_res_accept;
  logic                             w_res_last;
  logic                             w_abort;
  logic                             w_err;

  assign w_read_data = {i_read_v7, i_read_v6, i_read_v5, i_read_v4,
                        i_read_v3, i_read_v2, i_read_v1, i_read_v0};

  assign w_capture     = (r_state == StIdle) && i_start;
  assign w_send_active = (r_state == StSend);
  assign w_res_accept  = (r_state == StRecv) && i_res_valid;
  assign w_res_last    = w_res_accept && is_last_res(r_ridx);

  vreg_serializer u_serializer (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_capture   (w_capture),
    .i_read_data (w_read_data),
    .i_active    (w_send_active),
    .i_out_ready (i_out_ready),
    .o_out_data  (o_out_data),
    .o_out_idx   (o_out_idx),
    .o_out_valid (o_out_valid),
    .o_last      (w_send_last)
  );

  // Result buffer doubles as the write-back source, so it holds between transactions.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_res  <= '0;
      r_ridx <= '0;
    end else if (w_send_last) begin
      r_ridx <= '0;
    end else if (w_res_accept) begin
      r_res[r_ridx] <= i_res_data;
      if (!is_last_res(r_ridx)) begin
        r_ridx <= r_ridx + 1'b1;
      end
    end
  end

`ifdef VPU_REG_PORT_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TmoW-1:0] r_tmo;
  logic            r_err;

  // Abort on the idle RECV cycle that brings the count up to TIMEOUT_CYCLES.
  assign w_abort = (r_state == StRecv) && !i_res_valid &&
                   (r_tmo == TmoW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tmo <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_abort;
      if ((r_state != StRecv) || i_res_valid) begin
        r_tmo <= '0;
      end else begin
        r_tmo <= r_tmo + 1'b1;
      end
    end
  end

  assign w_err = r_err;
`else
  assign w_abort = 1'b0;
  assign w_err   = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (i_start) w_state_next = StSend;
      end
      StSend: begin
        if (w_send_last) w_state_next = StRecv;
      end
      StRecv: begin
        if (w_res_last) begin
          w_state_next = StWrite;
        end else if (w_abort) begin
          w_state_next = StIdle;
        end
      end
      StWrite: w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    o_busy      = (r_state != StIdle);
    o_done      = (r_state == StWrite);
    o_we_vpu    = (r_state == StWrite);
    o_res_ready = (r_state == StRecv);
    o_error     = w_err;
  end

  assign o_wrt_v0     = r_res[0];
  assign o_wrt_v1     = r_res[1];
  assign o_wrt_v2     = r_res[2];
  assign o_wrt_v3     = r_res[3];
  assign o_wrt_v4     = r_res[4];
  assign o_wrt_v5     = r_res[5];
  assign o_wrt_v6     = r_res[6];
  assign o_wrt_v7     = r_res[7];
  assign o_return_obj = r_res[8];

endmodule

// File: tb/tb_vpu_reg_port.sv
// Scoreboard bench for vpu_reg_port: the driver queues expected send words and write-backs
// per transaction; a negedge monitor pops and compares whenever the DUT presents them.
module tb_vpu_reg_port;
  import vpu_reg_port_pkg::*;

`ifdef VPU_REG_PORT_TIMEOUT_EN
  localparam int unsigned TmoCycles = 16;
`else
  localparam int unsigned TmoCycles = 256;
`endif

  typedef logic [RES_WORDS-1:0][DATA_W-1:0] wb_t;
  typedef logic [NUM_VREG-1:0][DATA_W-1:0]  regs_t;
  typedef struct packed {
    logic [2:0]  idx;
    logic [15:0] data;
  } send_t;

  logic        clk = 1'b0;
  logic        rst, start, out_ready, res_valid;
  regs_t       read_v;
  logic [15:0] res_data;
  logic [15:0] out_data, return_obj;
  logic [2:0]  out_idx;
  logic        out_valid, res_ready, we_vpu, busy, done, error;
  regs_t       wrt_v;

  always #5 clk = ~clk;

  vpu_reg_port #(.TIMEOUT_CYCLES(TmoCycles)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_read_v0    (read_v[0]),
    .i_read_v1    (read_v[1]),
    .i_read_v2    (read_v[2]),
    .i_read_v3    (read_v[3]),
    .i_read_v4    (read_v[4]),
    .i_read_v5    (read_v[5]),
    .i_read_v6    (read_v[6]),
    .i_read_v7    (read_v[7]),
    .o_out_data   (out_data),
    .o_out_idx    (out_idx),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .i_res_data   (res_data),
    .i_res_valid  (res_valid),
    .o_res_ready  (res_ready),
    .o_wrt_v0     (wrt_v[0]),
    .o_wrt_v1     (wrt_v[1]),
    .o_wrt_v2     (wrt_v[2]),
    .o_wrt_v3     (wrt_v[3]),
    .o_wrt_v4     (wrt_v[4]),
    .o_wrt_v5     (wrt_v[5]),
    .o_wrt_v6     (wrt_v[6]),
    .o_wrt_v7     (wrt_v[7]),
    .o_return_obj (return_obj),
    .o_we_vpu     (we_vpu),
    .o_busy       (busy),
    .o_done       (done),
    .o_error      (error)
  );

  int    n_cmp = 0;
  int    n_bad = 0;
  send_t exp_send[$];
  wb_t   exp_wb[$];
  int    wb_seen = 0;
  int    wb_expected = 0;
  int    err_seen = 0;
  bit    err_expected = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT offers a word or writes back.
  logic        stall_prev = 1'b0;
  logic [15:0] stall_data;
  logic [2:0]  stall_idx;
  send_t       m_s;
  wb_t         m_w;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        chk("stall_out_data", 32'(out_data), 32'(stall_data));
        chk("stall_out_idx", 32'(out_idx), 32'(stall_idx));
      end
      if (out_valid && out_ready) begin
        if (exp_send.size() == 0) begin
          chk("send_extra_word", 32'(out_valid), 32'd0);
        end else begin
          m_s = exp_send.pop_front();
          chk("out_idx", 32'(out_idx), 32'(m_s.idx));
          chk("out_data", 32'(out_data), 32'(m_s.data));
        end
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
      stall_idx  = out_idx;
      chk("send_recv_overlap", 32'(out_valid && res_ready), 32'd0);
      if (we_vpu || done) begin
        wb_seen++;
        chk("wb_we_and_done", 32'({we_vpu, done}), 32'd3);
        if (exp_wb.size() == 0) begin
          chk("wb_unexpected", 32'(we_vpu), 32'd0);
        end else begin
          m_w = exp_wb.pop_front();
          for (int i = 0; i < 8; i++) chk("wrt_v", 32'(wrt_v[i]), 32'(m_w[i]));
          chk("return_obj", 32'(return_obj), 32'(m_w[8]));
        end
      end
      if (error) begin
        err_seen++;
        if (!err_expected) chk("error_unexpected", 32'(error), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    logic [15:0] orr;
    orr = '0;
    for (int i = 0; i < 8; i++) orr |= wrt_v[i];
    chk({tag, "_ctl"}, 32'({busy, done, error, we_vpu, out_valid, res_ready}), 32'd0);
    chk({tag, "_out_data"}, 32'(out_data), 32'd0);
    chk({tag, "_out_idx"}, 32'(out_idx), 32'd0);
    chk({tag, "_wrt_v"}, 32'(orr), 32'd0);
    chk({tag, "_return_obj"}, 32'(return_obj), 32'd0);
  endtask

  task automatic check_hold(input wb_t res);
    for (int i = 0; i < 8; i++) chk("hold_wrt_v", 32'(wrt_v[i]), 32'(res[i]));
    chk("hold_return_obj", 32'(return_obj), 32'(res[8]));
    chk("idle_after_txn", 32'(busy), 32'd0);
  endtask

  // One transaction. stop_at>=0: stop offering results after that many beats (timeout).
  // rst_at>=0: return once that many beats are accepted so the caller can reset.
  task automatic run_txn(input regs_t regs, input wb_t res, input int rdy_pct,
                         input int vld_pct, input int stop_at, input int rst_at,
                         input bit poke_start, output int lat, output int idle_recv);
    int k;
    int cyc;
    bit acc;
    bit fin;
    read_v = regs;
    start  = 1'b1;
    for (int i = 0; i < 8; i++) exp_send.push_back({3'(i), regs[i]});
    if (stop_at < 0 && rst_at < 0) begin
      exp_wb.push_back(res);
      wb_expected++;
    end
    tick();
    start     = 1'b0;
    k         = 0;
    cyc       = 0;
    fin       = 1'b0;
    lat       = -1;
    idle_recv = 0;
    while (!fin && cyc < 3000) begin
      out_ready = ($urandom_range(99) < rdy_pct);
      res_valid = (stop_at < 0 || k < stop_at) && ($urandom_range(99) < vld_pct);
      res_data  = (k < 9) ? res[k] : 16'($urandom);
      start     = poke_start && (cyc == 3 || cyc == 12);
      read_v    = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      acc = res_valid && res_ready;
      if (res_ready && !res_valid) idle_recv++;
      if (done || error) begin
        fin = 1'b1;
        lat = cyc;
      end
      @(posedge clk);
      #1;
      if (acc) k++;
      cyc++;
      if (rst_at >= 0 && k == rst_at) fin = 1'b1;
    end
    start     = 1'b0;
    out_ready = 1'b0;
    res_valid = 1'b0;
    if (!fin) chk("txn_hung_cycles", 32'(cyc), 32'd0);
  endtask

  regs_t r;
  wb_t   w;
  int    lat;
  int    idle;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    res_valid = 1'b0;
    res_data  = '0;
    read_v    = '0;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Fixed register image and result words at full throughput.
    r = {16'hCCEE, 16'h88AD, 16'hFF99, 16'hAB56, 16'h1234, 16'hDEF3, 16'hA165, 16'hABCD};
    w = {16'h0017, 16'h0008, 16'h0007, 16'h0006, 16'h0005,
         16'h0004, 16'h0003, 16'h0002, 16'h0001};
    run_txn(r, w, 100, 100, -1, -1, 1'b0, lat, idle);
    // done sits 17 edges after the start edge: cycle 19 counting the start cycle as 1.
    chk("latency_start_to_done", 32'(lat), 32'd17);
    check_hold(w);

    // Back-to-back random transactions with stalls, gaps and stray starts while busy.
    for (int t = 0; t < 8; t++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      w = {16'($urandom), $urandom, $urandom, $urandom, $urandom};
      run_txn(r, w, (t == 0) ? 50 : int'($urandom_range(30, 100)),
              int'($urandom_range(30, 100)), -1, -1, t[0], lat, idle);
      check_hold(w);
    end

    // Reset after five accepted result beats.
    r = {$urandom, $urandom, $urandom, $urandom};
    w = {16'($urandom), $urandom, $urandom, $urandom, $urandom};
    run_txn(r, w, 100, 100, -1, 5, 1'b0, lat, idle);
    chk("pre_reset_in_recv", 32'(res_ready), 32'd1);
    rst = 1'b1;
    tick();
    check_all_zero("mid_reset");
    rst = 1'b0;
    tick();
    check_all_zero("after_reset");
    run_txn(r, w, 70, 70, -1, -1, 1'b0, lat, idle);
    check_hold(w);

`ifdef VPU_REG_PORT_TIMEOUT_EN
    // Three beats then silence: abort after TmoCycles idle RECV cycles, no write-back.
    err_expected = 1'b1;
    r = {$urandom, $urandom, $urandom, $urandom};
    w = {16'($urandom), $urandom, $urandom, $urandom, $urandom};
    run_txn(r, w, 100, 100, 3, -1, 1'b1, lat, idle);
    chk("timeout_idle_recv_cycles", 32'(idle), 32'(TmoCycles));
    chk("timeout_error_pulses", 32'(err_seen), 32'd1);
    chk("timeout_error_one_cycle", 32'(error), 32'd0);
    chk("timeout_back_to_idle", 32'(busy), 32'd0);
    err_expected = 1'b0;
    w = {16'($urandom), $urandom, $urandom, $urandom, $urandom};
    run_txn(r, w, 100, 100, -1, -1, 1'b0, lat, idle);
    check_hold(w);
`endif

    tick();
    chk("writeback_count", 32'(wb_seen), 32'(wb_expected));
    chk("send_queue_drained", 32'(exp_send.size()), 32'd0);
    chk("wb_queue_drained", 32'(exp_wb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
